mem_access: RTL and testbench

Memory-access stage that sits directly downstream of the execute stage. It accepts the ALU result as the data address and the held second operand as the store data. It runs a request/acknowledge transaction with the data memory, with byte-lane steering, load extension and a bounded wait. It then hands the load data, ALU result and instruction control to write-back with a single-cycle `done_out` pulse.

---
 rtl/mem_access.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_access.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: data-memory request/ack with byte-lane steering,
// load extension and a bounded wait, handing results on to write-back.
package mem_access_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  wb_sel;
  } instr_structure;
endpackage

module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           done_in,
  input  logic [31:0]    addr_in,
  input  logic [31:0]    wdata_in,
  input  instr_structure iCont_in,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic [1:0]     mem_size,
  input  logic           load_unsigned,
  output logic           busy,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [31:0]    dmem_addr,
  output logic [3:0]     dmem_be,
  output logic [31:0]    dmem_wdata,
  input  logic [31:0]    dmem_rdata,
  input  logic           dmem_ack,
  output logic [31:0]    rdata_out,
  output logic [31:0]    alu_out,
  output instr_structure iCont_out,
  output logic           done_out,
  output logic [1:0]     err_code
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SZ_BYTE      = 2'b00;
  localparam logic [1:0] SZ_HALF      = 2'b01;
  localparam logic [1:0] SZ_WORD      = 2'b10;
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;
  localparam logic [7:0] CNT_LAST     = 8'(TIMEOUT_CYCLES - 1);

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] k);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << k;
      SZ_HALF: lane_be = 4'b0011 << k;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: lane_wdata = {4{data[7:0]}};
      SZ_HALF: lane_wdata = {2{data[15:0]}};
      default: lane_wdata = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] k,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = rdata >> {k, 3'b000};
    case (size)
      SZ_BYTE: load_extend = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: load_extend = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  state_t         state_r, state_nxt;
  logic [7:0]     cnt_r, cnt_nxt;
  logic [31:0]    addr_r, addr_nxt;
  logic [1:0]     size_r, size_nxt;
  logic           uns_r, uns_nxt;
  logic           read_r, read_nxt;
  instr_structure icont_hold_r, icont_hold_nxt;

  logic           req_r, req_nxt;
  logic           we_r, we_nxt;
  logic [31:0]    daddr_r, daddr_nxt;
  logic [3:0]     be_r, be_nxt;
  logic [31:0]    dwdata_r, dwdata_nxt;
  logic [31:0]    rdata_r, rdata_nxt;
  logic [31:0]    alu_r, alu_nxt;
  instr_structure icont_r, icont_nxt;
  logic           done_r, done_nxt;
  logic [1:0]     err_r, err_nxt;

  logic           mem_op_s;
  logic           illegal_s;
  logic           misalign_s;
  logic           imm_done_s;
  logic [1:0]     imm_err_s;

  // Classify the incoming op; anything not needing the memory completes at once
  assign mem_op_s   = mem_read | mem_write;
  assign illegal_s  = (mem_read & mem_write) | (mem_op_s & (mem_size == 2'b11));
  assign misalign_s = mem_op_s & (((mem_size == SZ_HALF) & addr_in[0]) |
                                  ((mem_size == SZ_WORD) & (addr_in[1:0] != 2'b00)));
  assign imm_done_s = illegal_s | misalign_s | ~mem_op_s;
  assign imm_err_s  = illegal_s ? ERR_ILLEGAL : (misalign_s ? ERR_MISALIGN : ERR_OK);

  // Next-state and next-output logic for the IDLE/WAIT handshake
  always_comb begin
    state_nxt      = state_r;
    cnt_nxt        = cnt_r;
    addr_nxt       = addr_r;
    size_nxt       = size_r;
    uns_nxt        = uns_r;
    read_nxt       = read_r;
    icont_hold_nxt = icont_hold_r;
    req_nxt        = req_r;
    we_nxt         = we_r;
    daddr_nxt      = daddr_r;
    be_nxt         = be_r;
    dwdata_nxt     = dwdata_r;
    rdata_nxt      = rdata_r;
    alu_nxt        = alu_r;
    icont_nxt      = icont_r;
    done_nxt       = 1'b0;
    err_nxt        = err_r;

    case (state_r)
      ST_IDLE: begin
        if (done_in) begin
          addr_nxt       = addr_in;
          size_nxt       = mem_size;
          uns_nxt        = load_unsigned;
          read_nxt       = mem_read;
          icont_hold_nxt = iCont_in;
          if (imm_done_s) begin
            done_nxt  = 1'b1;
            err_nxt   = imm_err_s;
            rdata_nxt = 32'h0000_0000;
            alu_nxt   = addr_in;
            icont_nxt = iCont_in;
          end else begin
            req_nxt    = 1'b1;
            we_nxt     = mem_write;
            daddr_nxt  = {addr_in[31:2], 2'b00};
            be_nxt     = lane_be(mem_size, addr_in[1:0]);
            dwdata_nxt = lane_wdata(mem_size, wdata_in);
            cnt_nxt    = 8'd0;
            state_nxt  = ST_WAIT;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Ack takes priority over a timeout landing in the same cycle
        if (dmem_ack) begin
          req_nxt   = 1'b0;
          done_nxt  = 1'b1;
          err_nxt   = ERR_OK;
          rdata_nxt = read_r ? load_extend(dmem_rdata, addr_r[1:0], size_r, uns_r) : 32'h0000_0000;
          alu_nxt   = addr_r;
          icont_nxt = icont_hold_r;
          state_nxt = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          req_nxt   = 1'b0;
          done_nxt  = 1'b1;
          err_nxt   = ERR_TIMEOUT;
          rdata_nxt = 32'h0000_0000;
          alu_nxt   = addr_r;
          icont_nxt = icont_hold_r;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt_r + 8'd1;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched operands and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      addr_r       <= 32'h0000_0000;
      size_r       <= 2'b00;
      uns_r        <= 1'b0;
      read_r       <= 1'b0;
      icont_hold_r <= '0;
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      daddr_r      <= 32'h0000_0000;
      be_r         <= 4'b0000;
      dwdata_r     <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
      alu_r        <= 32'h0000_0000;
      icont_r      <= '0;
      done_r       <= 1'b0;
      err_r        <= 2'b00;
    end else begin
      state_r      <= state_nxt;
      cnt_r        <= cnt_nxt;
      addr_r       <= addr_nxt;
      size_r       <= size_nxt;
      uns_r        <= uns_nxt;
      read_r       <= read_nxt;
      icont_hold_r <= icont_hold_nxt;
      req_r        <= req_nxt;
      we_r         <= we_nxt;
      daddr_r      <= daddr_nxt;
      be_r         <= be_nxt;
      dwdata_r     <= dwdata_nxt;
      rdata_r      <= rdata_nxt;
      alu_r        <= alu_nxt;
      icont_r      <= icont_nxt;
      done_r       <= done_nxt;
      err_r        <= err_nxt;
    end
  end

  assign busy       = (state_r == ST_WAIT);
  assign dmem_req   = req_r;
  assign dmem_we    = we_r;
  assign dmem_addr  = daddr_r;
  assign dmem_be    = be_r;
  assign dmem_wdata = dwdata_r;
  assign rdata_out  = rdata_r;
  assign alu_out    = alu_r;
  assign iCont_out  = icont_r;
  assign done_out   = done_r;
  assign err_code   = err_r;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (TIMEOUT_CYCLES = 4).
module tb_mem_access;
  import mem_access_pkg::*;

  logic           clk;
  logic           rst;
  logic           done_in;
  logic [31:0]    addr_in;
  logic [31:0]    wdata_in;
  instr_structure iCont_in;
  logic           mem_read;
  logic           mem_write;
  logic [1:0]     mem_size;
  logic           load_unsigned;
  logic           busy;
  logic           dmem_req;
  logic           dmem_we;
  logic [31:0]    dmem_addr;
  logic [3:0]     dmem_be;
  logic [31:0]    dmem_wdata;
  logic [31:0]    dmem_rdata;
  logic           dmem_ack;
  logic [31:0]    rdata_out;
  logic [31:0]    alu_out;
  instr_structure iCont_out;
  logic           done_out;
  logic [1:0]     err_code;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int viol  = 0;
  int dc;
  instr_structure ic;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .done_in(done_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .iCont_in(iCont_in), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .load_unsigned(load_unsigned), .busy(busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .rdata_out(rdata_out),
    .alu_out(alu_out), .iCont_out(iCont_out), .done_out(done_out), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completion pulses and upstream protocol violations mid-cycle
  always @(negedge clk) begin
    if (done_out) done_cnt = done_cnt + 1;
    if (done_in && busy) viol = viol + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_imm(input string tag, input logic [31:0] addr, input logic rd,
                        input logic wr, input logic [1:0] size, input logic [1:0] exp_err);
    done_in = 1'b1; addr_in = addr; mem_read = rd; mem_write = wr; mem_size = size;
    step;
    done_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    chk({tag, "_done"}, 64'(done_out), 64'd1);
    chk({tag, "_err"}, 64'(err_code), 64'(exp_err));
    chk({tag, "_req"}, 64'(dmem_req), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata_out), 64'd0);
    chk({tag, "_alu"}, 64'(alu_out), 64'(addr));
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rd, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    done_in = 1'b1; addr_in = addr; mem_read = 1'b1; mem_write = 1'b0;
    mem_size = size; load_unsigned = uns;
    step;
    done_in = 1'b0; mem_read = 1'b0; addr_in = 32'h0; load_unsigned = ~uns;
    chk({tag, "_req"}, 64'(dmem_req), 64'd1);
    chk({tag, "_be"}, 64'(dmem_be), 64'(exp_be));
    chk({tag, "_we"}, 64'(dmem_we), 64'd0);
    dmem_ack = 1'b1; dmem_rdata = rd;
    step;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk({tag, "_done"}, 64'(done_out), 64'd1);
    chk({tag, "_data"}, 64'(rdata_out), 64'(exp_data));
    chk({tag, "_err"}, 64'(err_code), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b0; done_in = 1'b0; addr_in = 32'h0; wdata_in = 32'h0; iCont_in = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; load_unsigned = 1'b0;
    dmem_rdata = 32'h0; dmem_ack = 1'b0;
    step; step;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_outs", 64'({dmem_we, dmem_be, err_code, done_out}), 64'd0);
    chk("rst_buses", 64'(dmem_addr | dmem_wdata | rdata_out | alu_out), 64'd0);
    chk("rst_icont", 64'(iCont_out), 64'd0);
    rst = 1'b1;
    step;

    // ALU-only, back-to-back
    ic = '{pc: 32'h0000_4000, rd: 5'd7, reg_write: 1'b1, wb_sel: 2'b01};
    done_in = 1'b1; addr_in = 32'h0000_1234; iCont_in = ic;
    step;
    chk("alu1_done", 64'(done_out), 64'd1);
    chk("alu1_alu", 64'(alu_out), 64'h1234);
    chk("alu1_icont", 64'(iCont_out), 64'(ic));
    chk("alu1_req", 64'(dmem_req), 64'd0);
    chk("alu1_rdata", 64'(rdata_out), 64'd0);
    addr_in = 32'h0000_5678;
    step;
    chk("alu2_done", 64'(done_out), 64'd1);
    chk("alu2_alu", 64'(alu_out), 64'h5678);
    done_in = 1'b0; addr_in = 32'h0;
    step;
    chk("alu_pulse", 64'(done_out), 64'd0);
    chk("alu_hold", 64'(alu_out), 64'h5678);

    // Byte store at 0x103, ack after 3 cycles; inputs scrambled after acceptance
    ic = '{pc: 32'h0000_4010, rd: 5'd0, reg_write: 1'b0, wb_sel: 2'b00};
    done_in = 1'b1; addr_in = 32'h0000_0103; wdata_in = 32'hAABB_CCDD; iCont_in = ic;
    mem_write = 1'b1; mem_size = 2'b00;
    step;
    done_in = 1'b0; mem_write = 1'b0; addr_in = 32'hDEAD_BEEF; wdata_in = 32'h0; iCont_in = '0;
    chk("bst_req", 64'(dmem_req), 64'd1);
    chk("bst_busy", 64'(busy), 64'd1);
    chk("bst_addr", 64'(dmem_addr), 64'h100);
    chk("bst_be", 64'(dmem_be), 64'b1000);
    chk("bst_wdata", 64'(dmem_wdata), 64'hDDDD_DDDD);
    chk("bst_we", 64'(dmem_we), 64'd1);
    chk("bst_nodone", 64'(done_out), 64'd0);
    step;
    chk("bst_hold", 64'({dmem_req, dmem_we, dmem_be, dmem_addr}), 64'({1'b1, 1'b1, 4'b1000, 32'h100}));
    step;
    dmem_ack = 1'b1;
    step;
    dmem_ack = 1'b0;
    chk("bst_done", 64'(done_out), 64'd1);
    chk("bst_reqdrop", 64'(dmem_req), 64'd0);
    chk("bst_rdata", 64'(rdata_out), 64'd0);
    chk("bst_alu", 64'(alu_out), 64'h103);
    chk("bst_icont", 64'(iCont_out), 64'(ic));
    step;
    chk("bst_pulse", 64'(done_out), 64'd0);

    // Half store at 0x102
    done_in = 1'b1; addr_in = 32'h0000_0102; wdata_in = 32'h1122_3344; mem_write = 1'b1;
    mem_size = 2'b01;
    step;
    done_in = 1'b0; mem_write = 1'b0;
    chk("hst_be", 64'(dmem_be), 64'b1100);
    chk("hst_wdata", 64'(dmem_wdata), 64'h3344_3344);
    dmem_ack = 1'b1;
    step;
    dmem_ack = 1'b0;
    chk("hst_done", 64'(done_out), 64'd1);

    // Loads from 0x102 and a word load
    do_load("lsb", 32'h0000_0102, 2'b00, 1'b0, 32'h80FF_7F01, 4'b0100, 32'hFFFF_FFFF);
    do_load("luh", 32'h0000_0102, 2'b01, 1'b1, 32'h80FF_7F01, 4'b1100, 32'h0000_80FF);
    do_load("lsh", 32'h0000_0102, 2'b01, 1'b0, 32'h80FF_7F01, 4'b1100, 32'hFFFF_80FF);
    do_load("lub", 32'h0000_0101, 2'b00, 1'b1, 32'h80FF_7F01, 4'b0010, 32'h0000_007F);
    do_load("lw",  32'h0000_0100, 2'b10, 1'b0, 32'h80FF_7F01, 4'b1111, 32'h80FF_7F01);

    // Misaligned, illegal and plain ops complete in one cycle
    do_imm("mis_w", 32'h0000_0101, 1'b1, 1'b0, 2'b10, 2'b01);
    do_imm("mis_h", 32'h0000_0103, 1'b0, 1'b1, 2'b01, 2'b01);
    do_imm("ill_rw", 32'h0000_0100, 1'b1, 1'b1, 2'b10, 2'b11);
    do_imm("ill_sz", 32'h0000_0100, 1'b1, 1'b0, 2'b11, 2'b11);
    do_imm("none_odd", 32'h0000_0103, 1'b0, 1'b0, 2'b11, 2'b00);

    // Stray ack in IDLE
    dmem_ack = 1'b1;
    step;
    dmem_ack = 1'b0;
    chk("stray_done", 64'(done_out), 64'd0);
    chk("stray_req", 64'(dmem_req), 64'd0);

    // Timeout: request held for 4 cycles, then error 10
    done_in = 1'b1; addr_in = 32'h0000_0200; mem_read = 1'b1; mem_size = 2'b10;
    step;
    done_in = 1'b0; mem_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("to_req", 64'({dmem_req, done_out}), 64'b10);
      step;
    end
    chk("to_req_last", 64'({dmem_req, done_out}), 64'b10);
    step;
    chk("to_done", 64'(done_out), 64'd1);
    chk("to_err", 64'(err_code), 64'b10);
    chk("to_req_drop", 64'(dmem_req), 64'd0);
    chk("to_rdata", 64'(rdata_out), 64'd0);
    chk("to_alu", 64'(alu_out), 64'h200);

    // Ack on the final count wins
    done_in = 1'b1; addr_in = 32'h0000_0204; mem_read = 1'b1; mem_size = 2'b10;
    step;
    done_in = 1'b0; mem_read = 1'b0;
    step; step; step;
    chk("tack_req", 64'(dmem_req), 64'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    step;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("tack_done", 64'(done_out), 64'd1);
    chk("tack_err", 64'(err_code), 64'b00);
    chk("tack_data", 64'(rdata_out), 64'h1234_5678);

    // Reset in the middle of WAIT
    done_in = 1'b1; addr_in = 32'h0000_0300; mem_read = 1'b1; mem_size = 2'b10;
    step;
    done_in = 1'b0; mem_read = 1'b0;
    chk("rw_req_before", 64'(dmem_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rw_req_async", 64'(dmem_req), 64'd0);
    chk("rw_busy_async", 64'(busy), 64'd0);
    chk("rw_alu_clr", 64'(alu_out), 64'd0);
    dc = done_cnt;
    step;
    rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    step;
    chk("rw_no_done", 64'(done_cnt), 64'(dc));
    chk("rw_idle", 64'({busy, dmem_req, done_out}), 64'd0);
    do_imm("rw_next", 32'h0000_0055, 1'b0, 1'b0, 2'b00, 2'b00);

    step;
    chk("protocol_viol", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
